// File: rtl/impact_seq_pkg.sv
// impact_seq_pkg: shared state encoding and default phase lengths for the SRAM sequencer.
package impact_seq_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRECH = 3'd1,
        WLON  = 3'd2,
        SENSE = 3'd3,
        GAP   = 3'd4,
        RECOV = 3'd5
    } state_t;
    localparam int PRE_CYC_DEF   = 2;
    localparam int WL_CYC_DEF    = 2;
    localparam int SENSE_CYC_DEF = 1;
endpackage

// File: rtl/impact_sram_seq_if.sv
// impact_sram_seq_if: request/response bus of the SRAM access sequencer.
interface impact_sram_seq_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [1:0] req_proj;
    logic [1:0] req_byte_sel;
    logic       req_byte_mode;
    logic       req_trunc;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    modport master (
        output req_valid, req_we, req_proj, req_byte_sel, req_byte_mode, req_trunc, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_we, req_proj, req_byte_sel, req_byte_mode, req_trunc, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/impact_seq_timer.sv
// impact_seq_timer: loadable 4-bit down-counter; done while the count sits at zero.
module impact_seq_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       done
);
    logic [3:0] cnt;
    always_ff @(posedge clk) begin
        if (!rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - 4'd1;
    end
    assign done = cnt == '0;
endmodule

// File: rtl/impact_sram_seq.sv
// impact_sram_seq: precharge / word-line / sense sequencer for an SRAM macro.
// Define IMPACT_SEQ_WVERIFY_EN to add a read-back verify pass after every write.
module impact_sram_seq
    import impact_seq_pkg::*;
#(
    parameter int PRE_CYC   = PRE_CYC_DEF,
    parameter int WL_CYC    = WL_CYC_DEF,
    parameter int SENSE_CYC = SENSE_CYC_DEF
) (
    input  logic               clk,
    input  logic               rst,
    impact_sram_seq_if.slave   bus,
    output logic               PreCharge,
    output logic               WL_enable,
    output logic               ReadEnable,
    output logic               WriteEnable,
    output logic               Data_In_Enable,
    output logic               Byte_Mode_Enable,
    output logic               Trunc_Enable,
    output logic [1:0]         Proj_Select,
    output logic [1:0]         Byte_Select,
    output logic [7:0]         Data_In,
    input  logic [7:0]         Data_Out
);
    state_t     state, state_n;
    logic       rd, rd_n, ld, done, accept;
    logic [3:0] ld_val;

    assign accept = bus.req_valid && bus.req_ready;
    // rd marks the current pass as a read; the verify pass of a write flips it on in GAP
    assign rd_n = accept ? !bus.req_we : (state == GAP) || rd;

    impact_seq_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (ld),
        .load_val (ld_val),
        .done     (done)
    );

    always_comb begin
        state_n = state;
        ld      = 1'b0;
        ld_val  = 4'd0;
        case (state)
            IDLE:  if (accept) begin state_n = PRECH; ld = 1'b1; ld_val = 4'(PRE_CYC - 1); end
            PRECH: if (done) begin state_n = WLON; ld = 1'b1; ld_val = 4'(WL_CYC - 1); end
            WLON:  if (done) begin
                if (rd) begin state_n = SENSE; ld = 1'b1; ld_val = 4'(SENSE_CYC - 1); end
`ifdef IMPACT_SEQ_WVERIFY_EN
                else state_n = GAP;
`else
                else state_n = RECOV;
`endif
            end
            SENSE: if (done) state_n = RECOV;
            GAP:   begin state_n = PRECH; ld = 1'b1; ld_val = 4'(PRE_CYC - 1); end
            default: state_n = IDLE;
        endcase
    end

    // strobes are registered from the next state so they align with the state itself
    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= IDLE;
            rd               <= 1'b0;
            PreCharge        <= 1'b0;
            WL_enable        <= 1'b0;
            ReadEnable       <= 1'b0;
            WriteEnable      <= 1'b0;
            Data_In_Enable   <= 1'b0;
            Byte_Mode_Enable <= 1'b0;
            Trunc_Enable     <= 1'b0;
            Proj_Select      <= 2'b0;
            Byte_Select      <= 2'b0;
            Data_In          <= 8'h0;
            bus.req_ready    <= 1'b1;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_rdata    <= 8'h0;
        end else begin
            state          <= state_n;
            rd             <= rd_n;
            PreCharge      <= state_n == PRECH;
            WL_enable      <= state_n == WLON || state_n == SENSE;
            ReadEnable     <= (state_n == WLON && rd_n) || state_n == SENSE;
            WriteEnable    <= state_n == WLON && !rd_n;
            Data_In_Enable <= state_n == WLON && !rd_n;
            bus.req_ready  <= state_n == IDLE;
            bus.rsp_valid  <= state_n == RECOV;
            if (accept) begin
                Proj_Select      <= bus.req_proj;
                Byte_Select      <= bus.req_byte_sel;
                Byte_Mode_Enable <= bus.req_byte_mode;
                Trunc_Enable     <= bus.req_trunc;
                Data_In          <= bus.req_wdata;
            end
            if (state == SENSE && done) bus.rsp_rdata <= Data_Out;
        end
    end

`ifdef IMPACT_SEQ_WVERIFY_EN
    logic we_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            we_q        <= 1'b0;
            bus.rsp_err <= 1'b0;
        end else begin
            if (accept) we_q <= bus.req_we;
            bus.rsp_err <= state == SENSE && done && we_q && Data_Out != Data_In;
        end
    end
`else
    assign bus.rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_impact_sram_seq.sv
// tb_impact_sram_seq: directed and random accesses checked against a phase-timeline model.
module tb_impact_sram_seq;
    localparam int P = 2, W = 2, S = 1;
`ifdef IMPACT_SEQ_WVERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    logic       clk = 1'b0, rst = 1'b0;
    logic [7:0] data_out = 8'h0;
    logic       PreCharge, WL_enable, ReadEnable, WriteEnable, Data_In_Enable;
    logic       Byte_Mode_Enable, Trunc_Enable;
    logic [1:0] Proj_Select, Byte_Select;
    logic [7:0] Data_In;
    int         n_chk = 0, n_fail = 0, cyc = 0;
    int         acc[$];
    logic [7:0] last_rd = 8'h0;

    impact_sram_seq_if bus();

    impact_sram_seq #(.PRE_CYC(P), .WL_CYC(W), .SENSE_CYC(S)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .PreCharge        (PreCharge),
        .WL_enable        (WL_enable),
        .ReadEnable       (ReadEnable),
        .WriteEnable      (WriteEnable),
        .Data_In_Enable   (Data_In_Enable),
        .Byte_Mode_Enable (Byte_Mode_Enable),
        .Trunc_Enable     (Trunc_Enable),
        .Proj_Select      (Proj_Select),
        .Byte_Select      (Byte_Select),
        .Data_In          (Data_In),
        .Data_Out         (data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int lat(input logic w);
        return !w ? P + W + S + 1 : (VERIFY ? 2*P + 2*W + S + 2 : P + W + 1);
    endfunction

    // {PreCharge, WL_enable, ReadEnable, WriteEnable, Data_In_Enable, rsp_valid, req_ready}
    // for cycle k after the accept edge
    function automatic logic [6:0] model(input logic w, input int k);
        logic pre, re, wr, v, rdy;
        int   l;
        l   = lat(w);
        rdy = k > l;
        v   = k == l;
        if (w && VERIFY) begin
            pre = (k >= 1 && k <= P) || (k >= P + W + 2 && k <= 2*P + W + 1);
            wr  = k >= P + 1 && k <= P + W;
            re  = k >= 2*P + W + 2 && k <= 2*P + 2*W + S + 1;
        end else begin
            pre = k >= 1 && k <= P;
            wr  = w && k > P && k <= P + W;
            re  = !w && k > P && k <= P + W + S;
        end
        return {pre, wr || re, re, wr, wr, v, rdy};
    endfunction

    function automatic logic [6:0] obs_strobes();
        return {PreCharge, WL_enable, ReadEnable, WriteEnable, Data_In_Enable, bus.rsp_valid, bus.req_ready};
    endfunction

    // entered on a falling edge with the sequencer idle; returns on the first idle falling edge
    task automatic txn(input logic w, input logic [1:0] proj, input logic [1:0] bsel, input logic bm,
                       input logic tr, input logic [7:0] wd, input logic [7:0] dout, input bit hold);
        int         l;
        logic [7:0] exp_rd;
        l = lat(w);
        chk("ready_at_issue", bus.req_ready, 1'b1);
        bus.req_valid = 1'b1; bus.req_we = w; bus.req_proj = proj; bus.req_byte_sel = bsel;
        bus.req_byte_mode = bm; bus.req_trunc = tr; bus.req_wdata = wd;
        data_out = dout;
        @(posedge clk);
        for (int k = 1; k <= l + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                acc.push_back(cyc);
                if (hold) begin
                    bus.req_we = 1'($urandom); bus.req_proj = 2'($urandom); bus.req_byte_sel = 2'($urandom);
                    bus.req_byte_mode = 1'($urandom); bus.req_trunc = 1'($urandom); bus.req_wdata = 8'($urandom);
                end else bus.req_valid = 1'b0;
            end
            chk("strobes", {1'b0, obs_strobes()}, {1'b0, model(w, k)});
            if (k <= l) begin
                chk("proj_sel", Proj_Select, proj);
                chk("byte_sel", Byte_Select, bsel);
                chk("byte_mode", Byte_Mode_Enable, bm);
                chk("trunc", Trunc_Enable, tr);
                chk("data_in", Data_In, wd);
            end
            if (k == l) begin
                exp_rd = (!w || VERIFY) ? dout : last_rd;
                last_rd = exp_rd;
                chk("rsp_rdata", bus.rsp_rdata, exp_rd);
                chk("rsp_err", bus.rsp_err, VERIFY && w && dout != wd);
            end
        end
    endtask

    always @(negedge clk) begin
        chk("pre_wl_excl", PreCharge & WL_enable, 1'b0);
        chk("re_we_excl", ReadEnable & WriteEnable, 1'b0);
    end

    initial begin
        logic       w;
        logic [7:0] wd, dout;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_proj = 2'b0; bus.req_byte_sel = 2'b0;
        bus.req_byte_mode = 1'b0; bus.req_trunc = 1'b0; bus.req_wdata = 8'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_strobes", {1'b0, obs_strobes()}, 8'b0000_0001);
        chk("reset_rdata", bus.rsp_rdata, 8'h0);
        chk("reset_data_in", Data_In, 8'h0);
        chk("reset_proj", Proj_Select, 2'b0);
        chk("reset_bsel", Byte_Select, 2'b0);
        chk("reset_err", bus.rsp_err, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        txn(1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b0);
        txn(1'b1, 2'b00, 2'b10, 1'b1, 1'b0, 8'h3C, 8'hC3, 1'b0);
        acc.delete();
        txn(1'b0, 2'b10, 2'b01, 1'b0, 1'b1, 8'h11, 8'h5E, 1'b1);
        txn(1'b0, 2'b11, 2'b11, 1'b1, 1'b1, 8'h22, 8'h96, 1'b1);
        txn(1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 8'h33, 8'h0F, 1'b0);
        chk("b2b_gap_0", 8'(acc[1] - acc[0]), 8'(P + W + S + 2));
        chk("b2b_gap_1", 8'(acc[2] - acc[1]), 8'(P + W + S + 2));
        // reset in the middle of a read's word-line phase
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_proj = 2'b01; data_out = 8'h77;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_strobes", {1'b0, obs_strobes()}, 8'b0000_0001);
        chk("abort_rdata", bus.rsp_rdata, 8'h0);
        last_rd = 8'h0;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", {1'b0, obs_strobes()}, 8'b0000_0001);
        end
        for (int i = 0; i < 24; i++) begin
            w    = 1'($urandom);
            wd   = 8'($urandom);
            dout = w ? ($urandom_range(0, 1) ? wd : wd ^ (8'h01 << $urandom_range(0, 7))) : 8'($urandom);
            txn(w, 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), wd, dout, 1'($urandom));
        end
        bus.req_valid = 1'b0;
        @(negedge clk);
        txn(1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 8'h5A, 8'h5B, 1'b0);
        txn(1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 8'h5A, 8'h5A, 1'b0);
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/impact_sram_seq.md
IMPACT_SRAM_SEQ -- requirements
Module: impact_sram_seq

Interface
REQ-001 The block SHALL have parameter PRE_CYC, default 2: PreCharge pulse length in clk cycles, legal range 1..15.
REQ-002 The block SHALL have parameter WL_CYC, default 2: word-line pulse length in clk cycles, legal range 1..15.
REQ-003 The block SHALL have parameter SENSE_CYC, default 1: read sense window after WL_CYC in clk cycles, legal range 1..15.
REQ-004 The block SHALL have one clock; reset is synchronous and active-low, and the clock and reset ports are named as in the codebase: clk and rst.
REQ-005 The block SHALL have port clk, input, width 1: sole clock, rising edge.
REQ-006 The block SHALL have port rst, input, width 1: synchronous active-low reset.
REQ-007 The block SHALL have ports req_valid (input, 1) and req_ready (output, 1): access request handshake.
REQ-008 The block SHALL have request field inputs req_we (1), req_proj (2), req_byte_sel (2), req_byte_mode (1), req_trunc (1) and req_wdata (8).
REQ-009 The block SHALL have response outputs rsp_valid (1), rsp_rdata (8) and rsp_err (1).
REQ-010 The block SHALL have array-side outputs PreCharge, WL_enable, ReadEnable, WriteEnable, Data_In_Enable, Byte_Mode_Enable and Trunc_Enable (1 each), plus Proj_Select (2), Byte_Select (2) and Data_In (8).
REQ-011 The block SHALL have array-side input Data_Out, width 8.

Function
REQ-012 The block SHALL implement FSM states IDLE, PRECH, WLON, SENSE, GAP and RECOV.
REQ-013 In IDLE, req_ready SHALL be 1; in every other state it SHALL be 0.
REQ-014 A request SHALL be accepted only on a cycle with req_valid=1 and req_ready=1; all req_* fields SHALL be latched on that edge and the FSM SHALL move to PRECH.
REQ-015 In PRECH, PreCharge SHALL be 1 for exactly PRE_CYC cycles; the FSM SHALL then move to WLON.
REQ-016 In WLON, WL_enable SHALL be 1 for exactly WL_CYC cycles.
REQ-017 In WLON for a write, WriteEnable and Data_In_Enable SHALL be 1, and the FSM SHALL then move to RECOV.
REQ-018 In WLON for a read, ReadEnable SHALL be 1, and the FSM SHALL then move to SENSE.
REQ-019 In SENSE, WL_enable and ReadEnable SHALL remain 1 for SENSE_CYC cycles.
REQ-020 On the last SENSE cycle, Data_Out SHALL be registered into rsp_rdata; the FSM SHALL then move to RECOV.
REQ-021 RECOV SHALL last 1 cycle, with all array strobes at 0 and rsp_valid=1; the FSM SHALL then move to IDLE.
REQ-022 rsp_valid SHALL be a single-cycle pulse with no backpressure.
REQ-023 rsp_rdata SHALL hold its value until the next read capture.
REQ-024 Read latency from the accept edge to rsp_valid high SHALL be PRE_CYC+WL_CYC+SENSE_CYC+1 cycles (6 with defaults).
REQ-025 Write latency from the accept edge to rsp_valid high SHALL be PRE_CYC+WL_CYC+1 cycles (5 with defaults).
REQ-026 Proj_Select, Byte_Select, Byte_Mode_Enable, Trunc_Enable and Data_In SHALL be driven from the latched fields and held stable from PRECH through RECOV.
REQ-027 PreCharge and WL_enable SHALL never be 1 in the same cycle.
REQ-028 ReadEnable and WriteEnable SHALL never be 1 in the same cycle.
REQ-029 Every array output SHALL be driven from a flop.
REQ-030 The next request SHALL be acceptable on the first IDLE cycle after RECOV; back-to-back transactions SHALL therefore be separated by 1 RECOV cycle.
REQ-031 req_valid SHALL be ignored outside IDLE, and the latched fields SHALL be unaffected.

Reset
REQ-032 When rst=0 at a clk edge, the FSM SHALL go to IDLE.
REQ-033 When rst=0 at a clk edge, all array strobes, rsp_valid and rsp_err SHALL go to 0.
REQ-034 When rst=0 at a clk edge, rsp_rdata, Data_In, Proj_Select and Byte_Select SHALL go to 0 and req_ready SHALL go to 1.
REQ-035 A reset during any phase SHALL abort the access with no rsp_valid.

Configuration
REQ-036 Write-verify SHALL be compiled in by macro IMPACT_SEQ_WVERIFY_EN.
REQ-037 With IMPACT_SEQ_WVERIFY_EN defined, a write SHALL go WLON -> GAP (1 cycle, all strobes 0) -> PRECH -> WLON as a read -> SENSE -> RECOV.
REQ-038 With IMPACT_SEQ_WVERIFY_EN defined, the captured Data_Out SHALL be compared to the latched wdata and rsp_err=1 with rsp_valid on mismatch.
REQ-039 With IMPACT_SEQ_WVERIFY_EN defined, write latency SHALL be 2*PRE_CYC+2*WL_CYC+SENSE_CYC+2 cycles (11 with defaults).
REQ-040 Without IMPACT_SEQ_WVERIFY_EN, the GAP state SHALL be unreachable and rsp_err SHALL be tied to 0.

Structure
REQ-041 Package impact_seq_pkg SHALL hold the state enum and the default PRE/WL/SENSE constants.
REQ-042 A sub-module impact_seq_timer SHALL provide a loadable 4-bit down-counter with a done flag for phase timing.

Verification
REQ-043 Reset then read (proj=2'b01, Data_Out=8'hA5): PreCharge high on cycles 1-2, WL_enable and ReadEnable high on 3-5, rsp_valid on 6, rsp_rdata=8'hA5.
REQ-044 Write wdata=8'h3C, byte_mode=1, byte_sel=2'b10: WriteEnable and Data_In_Enable high on 3-4 with Data_In=8'h3C, rsp_valid on 5, Byte_Select held at 2'b10 throughout.
REQ-045 req_valid held high for 3 back-to-back reads: accepts are 7 cycles apart, and req_ready is 0 except in IDLE.
REQ-046 Assert rst=0 on cycle 3 of a read: all strobes are 0 next cycle, no rsp_valid, req_ready=1.
REQ-047 With IMPACT_SEQ_WVERIFY_EN, write 8'h5A with Data_Out returning 8'h5B: rsp_valid on cycle 11 with rsp_err=1; with Data_Out=8'h5A, rsp_err=0.
REQ-048 Assertions across all tests: PreCharge&WL_enable==0 and ReadEnable&WriteEnable==0 on every cycle.
